// File: rtl/execute_stage.sv
// Execute stage of the pipelined RV32I core: ID/EX register, forwarding, ALU,
// branch target and redirect logic, and the EX/MEM register.
module execute_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic [XLEN-1:0] imm_ext_d,
  input  logic [REGW-1:0] rs1_d,
  input  logic [REGW-1:0] rs2_d,
  input  logic [REGW-1:0] rd_d,
  input  logic [2:0]      alu_control_d,
  input  logic            alu_src_d,
  input  logic            reg_write_d,
  input  logic            mem_write_d,
  input  logic [1:0]      result_src_d,
  input  logic            branch_d,
  input  logic            jump_d,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  input  logic [XLEN-1:0] result_w,
  output logic [REGW-1:0] rs1_e,
  output logic [REGW-1:0] rs2_e,
  output logic [REGW-1:0] rd_e,
  output logic            result_src_e0,
  output logic            pcsrc_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [REGW-1:0] rd_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m
);

  logic [XLEN-1:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
  logic [2:0]      alu_control_e;
  logic            alu_src_e, reg_write_e, mem_write_e, branch_e, jump_e;
  logic [1:0]      result_src_e;

  logic [XLEN-1:0] srca, srcb, write_data_e, alu_result_e;
  logic            zero;

  // ID/EX: flush outranks stall so a bubble always lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush_e) begin
      rd1_e         <= '0;
      rd2_e         <= '0;
      pc_e          <= '0;
      pc_plus4_e    <= '0;
      imm_ext_e     <= '0;
      rs1_e         <= '0;
      rs2_e         <= '0;
      rd_e          <= '0;
      alu_control_e <= '0;
      alu_src_e     <= 1'b0;
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      result_src_e  <= '0;
      branch_e      <= 1'b0;
      jump_e        <= 1'b0;
    end else if (!stall_e) begin
      rd1_e         <= rd1_d;
      rd2_e         <= rd2_d;
      pc_e          <= pc_d;
      pc_plus4_e    <= pc_plus4_d;
      imm_ext_e     <= imm_ext_d;
      rs1_e         <= rs1_d;
      rs2_e         <= rs2_d;
      rd_e          <= rd_d;
      alu_control_e <= alu_control_d;
      alu_src_e     <= alu_src_d;
      reg_write_e   <= reg_write_d;
      mem_write_e   <= mem_write_d;
      result_src_e  <= result_src_d;
      branch_e      <= branch_d;
      jump_e        <= jump_d;
    end
  end

  always_comb begin
    srca = rd1_e;
    case (forward_a_e)
      2'b01:   srca = result_w;
      2'b10:   srca = alu_result_m;
      default: srca = rd1_e;
    endcase
  end

  always_comb begin
    write_data_e = rd2_e;
    case (forward_b_e)
      2'b01:   write_data_e = result_w;
      2'b10:   write_data_e = alu_result_m;
      default: write_data_e = rd2_e;
    endcase
  end

  assign srcb = alu_src_e ? imm_ext_e : write_data_e;

  always_comb begin
    alu_result_e = '0;
    case (alu_control_e)
      3'b000:  alu_result_e = srca + srcb;
      3'b001:  alu_result_e = srca - srcb;
      3'b010:  alu_result_e = srca & srcb;
      3'b011:  alu_result_e = srca | srcb;
      3'b101:  alu_result_e = {{(XLEN-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: alu_result_e = '0;
    endcase
  end

  assign zero          = (alu_result_e == '0);
  assign pcsrc_e       = (branch_e & zero) | jump_e;
  assign pc_target_e   = pc_e + imm_ext_e;
  assign result_src_e0 = result_src_e[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
    end else begin
      alu_result_m <= alu_result_e;
      write_data_m <= write_data_e;
      pc_plus4_m   <= pc_plus4_e;
      rd_m         <= rd_e;
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: hand-computed vectors checked with
// immediate assertions one cycle (E outputs) or two cycles (M outputs) after capture.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_e, flush_e;
  logic [31:0] rd1_d, rd2_d, pc_d, pc_plus4_d, imm_ext_d, result_w;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [2:0]  alu_control_d;
  logic        alu_src_d, reg_write_d, mem_write_d, branch_d, jump_d;
  logic [1:0]  result_src_d, forward_a_e, forward_b_e;

  logic [4:0]  rs1_e, rs2_e, rd_e, rd_m;
  logic        result_src_e0, pcsrc_e, reg_write_m, mem_write_m;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  logic [1:0]  result_src_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall_e(stall_e), .flush_e(flush_e),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .imm_ext_d(imm_ext_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .alu_control_d(alu_control_d), .alu_src_d(alu_src_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
    .result_src_d(result_src_d), .branch_d(branch_d), .jump_d(jump_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .result_w(result_w),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .result_src_e0(result_src_e0),
    .pcsrc_e(pcsrc_e), .pc_target_e(pc_target_e),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .pc_plus4_m(pc_plus4_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
    .mem_write_m(mem_write_m), .result_src_m(result_src_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    rd1_d = '0; rd2_d = '0; pc_d = '0; pc_plus4_d = '0; imm_ext_d = '0;
    rs1_d = '0; rs2_d = '0; rd_d = '0; alu_control_d = '0; alu_src_d = 1'b0;
    reg_write_d = 1'b0; mem_write_d = 1'b0; result_src_d = '0;
    branch_d = 1'b0; jump_d = 1'b0;
  endtask

  task automatic set_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [4:0] rd, input logic src, input logic [31:0] imm);
    clear_d();
    rd1_d = a; rd2_d = b; alu_control_d = op; rd_d = rd;
    alu_src_d = src; imm_ext_d = imm; reg_write_d = 1'b1;
  endtask

  logic [2:0]  ops  [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110};
  logic [31:0] exps [6] = '{32'h2, 32'h8, 32'h5, 32'hFFFF_FFFD, 32'h0, 32'h0};

  initial begin
    rst_n = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    forward_a_e = 2'b00; forward_b_e = 2'b00; result_w = '0;
    clear_d();
    #12;
    chk("rst_pcsrc", {31'b0, pcsrc_e}, 32'h0);
    chk("rst_pc_target", pc_target_e, 32'h0);
    chk("rst_alu_m", alu_result_m, 32'h0);
    chk("rst_ctrl_m", {27'b0, reg_write_m, mem_write_m, result_src_m, 1'b0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU operations, observed two edges after capture
    for (int i = 0; i < 6; i++) begin
      set_alu(32'h5, 32'hFFFF_FFFD, ops[i], 5'd3, 1'b0, 32'h0);
      tick();
      clear_d();
      tick();
      chk($sformatf("alu_op_%0d", ops[i]), alu_result_m, exps[i]);
    end
    set_alu(32'hFFFF_FFFD, 32'h5, 3'b101, 5'd7, 1'b0, 32'h0);
    tick();
    clear_d();
    tick();
    chk("slt_swapped", alu_result_m, 32'h1);
    chk("slt_rd_m", {27'b0, rd_m}, 32'd7);
    chk("slt_regw_m", {31'b0, reg_write_m}, 32'h1);

    // Forward A from alu_result_m
    set_alu(32'h100, 32'h0, 3'b000, 5'd1, 1'b0, 32'h0);
    tick();
    set_alu(32'hDEAD, 32'h0, 3'b000, 5'd2, 1'b1, 32'h4);
    tick();
    chk("fwd_a_src_m", alu_result_m, 32'h100);
    forward_a_e = 2'b10;
    clear_d();
    tick();
    forward_a_e = 2'b00;
    chk("fwd_a_add", alu_result_m, 32'h104);

    // Forward B from result_w on a store
    set_alu(32'h1000, 32'h55, 3'b000, 5'd0, 1'b1, 32'h8);
    reg_write_d = 1'b0; mem_write_d = 1'b1;
    tick();
    forward_b_e = 2'b01; result_w = 32'hAB;
    clear_d();
    tick();
    forward_b_e = 2'b00;
    chk("fwd_b_wdata", write_data_m, 32'hAB);
    chk("fwd_b_addr", alu_result_m, 32'h1008);
    chk("fwd_b_memw", {31'b0, mem_write_m}, 32'h1);

    // Select 11 behaves as 00
    set_alu(32'h1, 32'h77, 3'b000, 5'd0, 1'b0, 32'h0);
    tick();
    forward_a_e = 2'b11; forward_b_e = 2'b11;
    clear_d();
    tick();
    forward_a_e = 2'b00; forward_b_e = 2'b00;
    chk("fwd_11_wdata", write_data_m, 32'h77);
    chk("fwd_11_alu", alu_result_m, 32'h78);

    // Branch taken / not taken
    set_alu(32'h7, 32'h7, 3'b001, 5'd0, 1'b0, 32'hFFFF_FFF8);
    reg_write_d = 1'b0; branch_d = 1'b1; pc_d = 32'h40;
    tick();
    chk("beq_taken", {31'b0, pcsrc_e}, 32'h1);
    chk("beq_target", pc_target_e, 32'h38);
    rd2_d = 32'h8;
    tick();
    chk("beq_not_taken", {31'b0, pcsrc_e}, 32'h0);

    // Stall holds ID/EX
    set_alu(32'h0, 32'h0, 3'b000, 5'd12, 1'b0, 32'h0);
    rs1_d = 5'd9;
    tick();
    rs1_d = 5'd1; rd_d = 5'd2; stall_e = 1'b1;
    tick();
    chk("stall1_rs1", {27'b0, rs1_e}, 32'd9);
    chk("stall1_rd", {27'b0, rd_e}, 32'd12);
    tick();
    chk("stall2_rs1", {27'b0, rs1_e}, 32'd9);
    chk("stall2_rd", {27'b0, rd_e}, 32'd12);

    // Flush together with stall: bubble wins
    mem_write_d = 1'b1; branch_d = 1'b1; flush_e = 1'b1;
    tick();
    stall_e = 1'b0; flush_e = 1'b0;
    chk("flush_rd_e", {27'b0, rd_e}, 32'd0);
    chk("flush_pcsrc", {31'b0, pcsrc_e}, 32'h0);
    clear_d();
    tick();
    chk("flush_regw_m", {31'b0, reg_write_m}, 32'h0);
    chk("flush_memw_m", {31'b0, mem_write_m}, 32'h0);
    chk("flush_rd_m", {27'b0, rd_m}, 32'd0);

    // Jump
    clear_d();
    jump_d = 1'b1; result_src_d = 2'b10; pc_plus4_d = 32'h14; pc_d = 32'h10;
    imm_ext_d = 32'h20; reg_write_d = 1'b1; rd_d = 5'd1;
    tick();
    chk("jal_pcsrc", {31'b0, pcsrc_e}, 32'h1);
    chk("jal_target", pc_target_e, 32'h30);
    chk("jal_rsrc_e0", {31'b0, result_src_e0}, 32'h0);
    clear_d();
    tick();
    chk("jal_pc4_m", pc_plus4_m, 32'h14);
    chk("jal_rsrc_m", {30'b0, result_src_m}, 32'h2);

    // Asynchronous reset with instructions in E and M
    set_alu(32'h3, 32'h4, 3'b000, 5'd5, 1'b0, 32'h0);
    mem_write_d = 1'b1;
    tick();
    set_alu(32'h1, 32'h1, 3'b000, 5'd6, 1'b0, 32'h0);
    jump_d = 1'b1;
    tick();
    chk("pre_rst_alu_m", alu_result_m, 32'h7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_regw_m", {31'b0, reg_write_m}, 32'h0);
    chk("arst_memw_m", {31'b0, mem_write_m}, 32'h0);
    chk("arst_alu_m", alu_result_m, 32'h0);
    chk("arst_rd_e", {27'b0, rd_e}, 32'd0);
    chk("arst_pcsrc", {31'b0, pcsrc_e}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_alu(32'h11, 32'h22, 3'b000, 5'd4, 1'b0, 32'h0);
    tick();
    clear_d();
    tick();
    chk("post_rst_alu_m", alu_result_m, 32'h33);
    chk("post_rst_rd_m", {27'b0, rd_m}, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage pipelined RV32I core, directly downstream of the ALU decoder.
- Holds the ID/EX pipeline register, which captures decoded control including the 3-bit alu_control.
- Contains forwarding muxes, the ALU, the branch/jump target adder and pcsrc generation, plus the EX/MEM pipeline register feeding the memory stage.
- Outputs rs1/rs2/rd to the hazard unit and accepts forward selects, stall and flush from it.

Parameters:
XLEN, 32, datapath width
REGW, 5, register-index width

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stall_e  in  1  hold ID/EX register
flush_e  in  1  load bubble into ID/EX
rd1_d  in  XLEN  rs1 read data from decode
rd2_d  in  XLEN  rs2 read data from decode
pc_d  in  XLEN  instruction PC
pc_plus4_d  in  XLEN  PC+4
imm_ext_d  in  XLEN  sign-extended immediate
rs1_d  in  REGW  source 1 index
rs2_d  in  REGW  source 2 index
rd_d  in  REGW  destination index
alu_control_d  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt
alu_src_d  in  1  1 selects imm_ext as ALU B
reg_write_d  in  1  register write enable
mem_write_d  in  1  store enable
result_src_d  in  2  00 alu, 01 mem, 10 pc+4
branch_d  in  1  beq
jump_d  in  1  jal
forward_a_e  in  2  00 regfile, 01 result_w, 10 alu_result_m
forward_b_e  in  2  same encoding for B
result_w  in  XLEN  writeback value
rs1_e  out  REGW  to hazard unit
rs2_e  out  REGW  to hazard unit
rd_e  out  REGW  to hazard unit
result_src_e0  out  1  load-in-E flag for hazard unit
pcsrc_e  out  1  redirect fetch
pc_target_e  out  XLEN  pc_e + imm_ext_e
alu_result_m  out  XLEN  EX/MEM registered ALU result
write_data_m  out  XLEN  forwarded store data
pc_plus4_m  out  XLEN  registered PC+4
rd_m  out  REGW  registered destination
reg_write_m  out  1  registered control
mem_write_m  out  1  registered control
result_src_m  out  2  registered control

Behaviour:
- Reset (rst_n low, asynchronous): all ID/EX and EX/MEM fields are 0. As a result all outputs are 0, including pcsrc_e and pc_target_e.
- ID/EX register update at each rising edge:
  - flush_e=1: all fields are cleared to 0. Flush has priority over stall.
  - else stall_e=1: the register holds its value.
  - else: the register loads the *_d inputs.
- EX/MEM register loads every cycle. It is never stalled or flushed.
- Forwarding is combinational in E:
  - srca = mux(forward_a_e: rd1_e, result_w, alu_result_m).
  - write_data_e = mux(forward_b_e: rd2_e, result_w, alu_result_m).
  - Select value 11 behaves as 00.
- srcb = alu_src_e ? imm_ext_e : write_data_e.
- ALU operations:
  - add/sub: modulo 2^XLEN, carry discarded.
  - slt: signed compare, result 1 or 0, zero-extended.
  - Undefined alu_control codes (100, 110, 111) produce 0.
- zero = (alu_result_e == 0).
- pcsrc_e = (branch_e & zero) | jump_e. It is combinational, valid in the same cycle as the E instruction.
- Latency: D inputs reach the E outputs 1 cycle after capture and the M outputs 2 cycles after capture.
- A bubble (flushed entry) has reg_write, mem_write, branch and jump all 0. It therefore never redirects fetch or writes state.
- Simultaneous stall_e and flush_e: flush wins.
- Reset asserted mid-instruction: in-flight E and M instructions are discarded with no write enables asserted. After rst_n deasserts, the first edge captures the D inputs normally.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately (asynchronous); after release, captured instruction appears on alu_result_m 2 edges later.
- ALU ops: rd1=0x0000_0005, rd2=0xFFFF_FFFD with codes 000/001/010/011/101 -> alu_result_m = 0x2, 0x8, 0x5, 0xFFFF_FFFD, 0x0. Swapping operands for slt gives 0x1.
- Forwarding: forward_a_e=10 with alu_result_m=0x100 -> add with imm 4 yields 0x104. forward_b_e=01 with result_w=0xAB on a store -> write_data_m=0xAB.
- Branch: branch_d=1, rd1=rd2=7, pc_d=0x40, imm=0xFFFF_FFF8 -> pcsrc_e=1 and pc_target_e=0x38. With rd2=8 -> pcsrc_e=0.
- Stall/flush: stall_e=1 for 2 cycles -> rs1_e/rd_e hold. flush_e=1 together with stall_e=1 -> next cycle reg_write_m=0, mem_write_m=0, rd_m=0.
- Jump: jump_d=1, result_src_d=10, pc_plus4_d=0x14 -> pcsrc_e=1; next cycle pc_plus4_m=0x14 and result_src_m=10.
